// File: rtl/fir_axil_pkg.sv
// Shared constants, state types and address decode for the FIR AXI4-Lite register slave.
package fir_axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam logic [4:0] REG0_OFS   = 5'h00;
  localparam logic [4:0] REG1_OFS   = 5'h04;
  localparam logic [4:0] REG2_OFS   = 5'h08;
  localparam logic [4:0] REG3_OFS   = 5'h0C;
  localparam logic [4:0] STATUS_OFS = 5'h10;

  localparam int         NUM_REGS     = 4;
  localparam logic [2:0] STATUS_IDX   = 3'd4;
  localparam logic [2:0] UNMAPPED_IDX = 3'd7;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Takes the word address (byte address bits [4:2]); 0-3 are RW, 4 is status, 7 is unmapped.
  function automatic logic [2:0] addr_to_index(input logic [2:0] word_addr);
    logic [4:0] ofs;
    ofs = {word_addr, 2'b00};
    case (ofs)
      REG0_OFS:   return 3'd0;
      REG1_OFS:   return 3'd1;
      REG2_OFS:   return 3'd2;
      REG3_OFS:   return 3'd3;
      STATUS_OFS: return STATUS_IDX;
      default:    return UNMAPPED_IDX;
    endcase
  endfunction

endpackage

// File: rtl/fir_axil_reg_bank.sv
// Four RW control registers with byte-strobe merge and one-cycle commit pulses.
module fir_axil_reg_bank
  import fir_axil_pkg::*;
#(
  parameter logic [31:0] REG_RESET_VAL = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [1:0]            index,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic [NUM_REGS*32-1:0] ctrl_regs,
  output logic [NUM_REGS-1:0]   wr_pulse
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] value_reg;
      logic        pulse_reg;
      logic        hit;

      assign hit = we && (index == gi[1:0]);

      always_ff @(posedge clock) begin
        if (reset) begin
          value_reg <= REG_RESET_VAL;
          pulse_reg <= 1'b0;
        end else begin
          // A write with no strobes set is still acknowledged upstream but is not a commit here.
          pulse_reg <= hit && (wstrb != 4'b0000);
          if (hit) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) value_reg[8*b +: 8] <= wdata[8*b +: 8];
            end
          end
        end
      end

      assign ctrl_regs[32*gi +: 32] = value_reg;
      assign wr_pulse[gi]           = pulse_reg;
    end
  endgenerate

endmodule

// File: rtl/fir_axil_slave_regs.sv
// AXI4-Lite slave front end: independent single-outstanding write and read FSMs over the register bank.
module fir_axil_slave_regs
  import fir_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] REG_RESET_VAL      = 32'h0000_0000
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
  output logic [3:0]                      reg_wr_pulse,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   status_in
);

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------- write channel ----------------
  w_state_t    w_state_reg;
  logic        awready_reg, wready_reg, bvalid_reg;
  logic [1:0]  bresp_reg;
  logic        aw_latched_reg, w_latched_reg;
  logic [2:0]  waddr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;

  logic        aw_hs, w_hs, commit, bank_we;
  logic [2:0]  cmt_idx;
  logic [31:0] cmt_data;
  logic [3:0]  cmt_strb;

  assign aw_hs    = s_axi_awvalid && awready_reg;
  assign w_hs     = s_axi_wvalid && wready_reg;
  // Commit as soon as both halves are available, whether latched earlier or arriving now.
  assign commit   = (w_state_reg == W_IDLE) && (aw_latched_reg || aw_hs) && (w_latched_reg || w_hs);
  assign cmt_idx  = addr_to_index(aw_latched_reg ? waddr_reg : s_axi_awaddr[4:2]);
  assign cmt_data = w_latched_reg ? wdata_reg : s_axi_wdata;
  assign cmt_strb = w_latched_reg ? wstrb_reg : s_axi_wstrb;
  assign bank_we  = commit && (cmt_idx < STATUS_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_reg    <= W_IDLE;
      awready_reg    <= 1'b0;
      wready_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      bresp_reg      <= OKAY;
      aw_latched_reg <= 1'b0;
      w_latched_reg  <= 1'b0;
      waddr_reg      <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (commit) begin
            bvalid_reg     <= 1'b1;
            bresp_reg      <= (cmt_idx <= STATUS_IDX) ? OKAY : SLVERR;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            aw_latched_reg <= 1'b0;
            w_latched_reg  <= 1'b0;
            w_state_reg    <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_latched_reg <= 1'b1;
              waddr_reg      <= s_axi_awaddr[4:2];
            end
            if (w_hs) begin
              w_latched_reg <= 1'b1;
              wdata_reg     <= s_axi_wdata;
              wstrb_reg     <= s_axi_wstrb;
            end
            awready_reg <= !(aw_latched_reg || aw_hs);
            wready_reg  <= !(w_latched_reg || w_hs);
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: w_state_reg <= W_IDLE;
      endcase
    end
  end

  fir_axil_reg_bank #(.REG_RESET_VAL(REG_RESET_VAL)) u_bank (
    .clock     (clock),
    .reset     (reset),
    .we        (bank_we),
    .index     (cmt_idx[1:0]),
    .wdata     (cmt_data),
    .wstrb     (cmt_strb),
    .ctrl_regs (ctrl_regs),
    .wr_pulse  (reg_wr_pulse)
  );

  // ---------------- read channel ----------------
  r_state_t    r_state_reg;
  logic        arready_reg, rvalid_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;
  logic        ar_hs;
  logic [2:0]  rd_idx;
  logic [31:0] rd_word;

  assign ar_hs  = s_axi_arvalid && arready_reg;
  assign rd_idx = addr_to_index(s_axi_araddr[4:2]);

  // Sampling the bank outputs gives pre-commit values when a write closes on the same edge.
  always_comb begin
    rd_word = '0;
    if (rd_idx < STATUS_IDX)       rd_word = ctrl_regs[{rd_idx[1:0], 5'b00000} +: 32];
    else if (rd_idx == STATUS_IDX) rd_word = status_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= OKAY;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_reg   <= rd_word;
            rresp_reg   <= (rd_idx <= STATUS_IDX) ? OKAY : SLVERR;
            rvalid_reg  <= 1'b1;
            arready_reg <= 1'b0;
            r_state_reg <= R_DATA;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        default: r_state_reg <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_reg;
  assign s_axi_wready  = wready_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_arready = arready_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;

endmodule

// File: tb/tb_fir_axil_slave_regs.sv
// Self-checking bench for fir_axil_slave_regs against a register-map reference model.
module tb_fir_axil_slave_regs;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   s_axi_awaddr = '0;
  logic [2:0]   s_axi_awprot = '0;
  logic         s_axi_awvalid = 1'b0;
  logic         s_axi_awready;
  logic [31:0]  s_axi_wdata = '0;
  logic [3:0]   s_axi_wstrb = '0;
  logic         s_axi_wvalid = 1'b0;
  logic         s_axi_wready;
  logic [1:0]   s_axi_bresp;
  logic         s_axi_bvalid;
  logic         s_axi_bready = 1'b0;
  logic [4:0]   s_axi_araddr = '0;
  logic [2:0]   s_axi_arprot = '0;
  logic         s_axi_arvalid = 1'b0;
  logic         s_axi_arready;
  logic [31:0]  s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rvalid;
  logic         s_axi_rready = 1'b0;
  logic [127:0] ctrl_regs;
  logic [3:0]   reg_wr_pulse;
  logic [31:0]  status_in = '0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [4];

  always #5 clock = ~clock;

  fir_axil_slave_regs dut (
    .clock(clock), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .ctrl_regs(ctrl_regs), .reg_wr_pulse(reg_wr_pulse),
    .status_in(status_in)
  );

  // ---------------- reference model ----------------
  function automatic logic [127:0] model_vec();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic logic [1:0] exp_resp(input logic [4:0] addr);
    return (addr[4:2] <= 3'd4) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [3:0] exp_pulse(input logic [4:0] addr, input logic [3:0] strb);
    if (addr[4:2] < 3'd4 && strb != 4'h0) return 4'b0001 << addr[3:2];
    return 4'b0000;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] addr);
    if (addr[4:2] < 3'd4)  return model[addr[3:2]];
    if (addr[4:2] == 3'd4) return status_in;
    return 32'h0;
  endfunction

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr[4:2] < 3'd4)
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  // ---------------- bus drivers (return observations, no checking) ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_delay, input int w_delay,
                          output logic [1:0] resp, output logic [3:0] pulse, output bit timeout);
    int  cyc = 0;
    bit  aw_done = 0, w_done = 0, got = 0;
    timeout = 0;
    resp = 2'bxx;
    pulse = 4'bxxxx;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb; s_axi_bready = 1'b1;
    while (!(aw_done && w_done) && !timeout) begin
      s_axi_awvalid = !aw_done && (cyc >= aw_delay);
      s_axi_wvalid  = !w_done && (cyc >= w_delay);
      @(negedge clock);
      if (s_axi_awvalid && s_axi_awready) aw_done = 1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1;
      @(posedge clock); #1;
      cyc++;
      if (cyc > 50) timeout = 1;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int i = 0; i < 20 && !got && !timeout; i++) begin
      @(negedge clock);
      if (i == 0) pulse = reg_wr_pulse;
      if (s_axi_bvalid) begin resp = s_axi_bresp; got = 1; end
      @(posedge clock); #1;
    end
    if (!got) timeout = 1;
    s_axi_bready = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output bit timeout);
    bit done = 0, got = 0;
    timeout = 0;
    data = 'x; resp = 'x;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (s_axi_arready) done = 1;
      @(posedge clock); #1;
    end
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 20 && !got && done; i++) begin
      @(negedge clock);
      if (s_axi_rvalid) begin data = s_axi_rdata; resp = s_axi_rresp; got = 1; end
      @(posedge clock); #1;
    end
    if (!got) timeout = 1;
    s_axi_rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
      n_err++; $display("FAIL reset_readies_low: got %b expected 000", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    n_vec++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_err++; $display("FAIL reset_readies_rise: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    n_vec++;
    if (ctrl_regs !== 128'h0) begin
      n_err++; $display("FAIL reset_ctrl_regs: got %h expected 0", ctrl_regs);
    end
    n_vec++;
    if ({s_axi_bvalid, s_axi_rvalid, reg_wr_pulse} !== 6'b0) begin
      n_err++; $display("FAIL reset_valids: got %b expected 000000", {s_axi_bvalid, s_axi_rvalid, reg_wr_pulse});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_basic_rw();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] data; bit to;
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a = 5'(4 * i);
      do_write(a, 32'(i + 1), 4'hF, 0, 0, resp, pulse, to);
      model_write(a, 32'(i + 1), 4'hF);
      n_vec++;
      if (to || resp !== 2'b00 || pulse !== (4'b0001 << i)) begin
        n_err++; $display("FAIL basic_write[%0d]: got resp=%b pulse=%b to=%0d expected resp=00 pulse=%b", i, resp, pulse, to, 4'b0001 << i);
      end
      $display("write addr=%h data=%h strb=F resp=%b pulse=%b", a, 32'(i + 1), resp, pulse);
    end
    for (int i = 0; i < 4; i++) begin
      logic [4:0] a = 5'(4 * i);
      do_read(a, data, resp, to);
      n_vec++;
      if (to || data !== 32'(i + 1) || resp !== 2'b00) begin
        n_err++; $display("FAIL basic_read[%0d]: got data=%h resp=%b expected data=%h resp=00", i, data, resp, 32'(i + 1));
      end
      $display("read  addr=%h data=%h resp=%b", a, data, resp);
    end
  endtask

  task automatic test_w_before_aw();
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    s_axi_awaddr = 5'h04;
    @(negedge clock);
    n_vec++;
    if (s_axi_wready !== 1'b1) begin n_err++; $display("FAIL wfirst_wready: got %b expected 1", s_axi_wready); end
    @(posedge clock); #1 s_axi_wvalid = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({s_axi_wready, s_axi_bvalid} !== 2'b00) begin
      n_err++; $display("FAIL wfirst_hold: got wready,bvalid=%b expected 00", {s_axi_wready, s_axi_bvalid});
    end
    @(posedge clock); #1;
    @(posedge clock); #1 s_axi_awvalid = 1'b1;
    @(negedge clock);
    n_vec++;
    if (s_axi_awready !== 1'b1) begin n_err++; $display("FAIL wfirst_awready: got %b expected 1", s_axi_awready); end
    @(posedge clock); #1 s_axi_awvalid = 1'b0;
    model_write(5'h04, 32'hDEADBEEF, 4'hF);
    @(negedge clock);
    n_vec++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      n_err++; $display("FAIL wfirst_bvalid: got bvalid=%b bresp=%b expected 1 00", s_axi_bvalid, s_axi_bresp);
    end
    n_vec++;
    if (ctrl_regs[63:32] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wfirst_reg1: got %h expected deadbeef", ctrl_regs[63:32]);
    end
    $display("write addr=04 data=deadbeef (W 3 cycles early) reg1=%h", ctrl_regs[63:32]);
    @(posedge clock); #1 s_axi_bready = 1'b0;
  endtask

  task automatic test_strobes();
    logic [1:0] resp; logic [3:0] pulse; bit to;
    do_write(5'h08, 32'h11223344, 4'hF, 0, 0, resp, pulse, to);
    model_write(5'h08, 32'h11223344, 4'hF);
    s_axi_awaddr = 5'h08; s_axi_wdata = 32'hAABBCCDD; s_axi_wstrb = 4'h5;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    @(negedge clock);
    n_vec++;
    if ({s_axi_awready, s_axi_wready} !== 2'b11) begin
      n_err++; $display("FAIL strb_accept: got %b expected 11", {s_axi_awready, s_axi_wready});
    end
    @(posedge clock); #1;
    s_axi_wvalid = 1'b0; s_axi_awaddr = 5'h00;   // keep offering a new AW during backpressure
    model_write(5'h08, 32'hAABBCCDD, 4'h5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_vec++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || s_axi_awready !== 1'b0) begin
        n_err++; $display("FAIL strb_hold[%0d]: got bvalid=%b bresp=%b awready=%b expected 1 00 0", i, s_axi_bvalid, s_axi_bresp, s_axi_awready);
      end
      @(posedge clock); #1;
    end
    s_axi_awvalid = 1'b0; s_axi_bready = 1'b1;
    @(posedge clock); #1 s_axi_bready = 1'b0;
    n_vec++;
    if (ctrl_regs[95:64] !== 32'h11BB33DD || ctrl_regs !== model_vec()) begin
      n_err++; $display("FAIL strb_merge: got %h expected %h", ctrl_regs, model_vec());
    end
    $display("write addr=08 data=aabbccdd strb=5 reg2=%h", ctrl_regs[95:64]);
  endtask

  task automatic test_status_unmapped();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] data; bit to;
    status_in = 32'h0000_00A5;
    do_read(5'h10, data, resp, to);
    n_vec++;
    if (to || data !== 32'hA5 || resp !== 2'b00) begin
      n_err++; $display("FAIL status_read: got data=%h resp=%b expected 000000a5 00", data, resp);
    end
    $display("read  addr=10 data=%h resp=%b", data, resp);
    do_write(5'h10, 32'h12345678, 4'hF, 0, 0, resp, pulse, to);
    n_vec++;
    if (to || resp !== 2'b00 || pulse !== 4'h0 || ctrl_regs !== model_vec()) begin
      n_err++; $display("FAIL status_write: got resp=%b pulse=%b regs=%h expected 00 0000 %h", resp, pulse, ctrl_regs, model_vec());
    end
    do_write(5'h18, 32'hCAFEF00D, 4'hF, 0, 0, resp, pulse, to);
    n_vec++;
    if (to || resp !== 2'b10 || pulse !== 4'h0 || ctrl_regs !== model_vec()) begin
      n_err++; $display("FAIL unmapped_write: got resp=%b pulse=%b regs=%h expected 10 0000 %h", resp, pulse, ctrl_regs, model_vec());
    end
    $display("write addr=18 resp=%b pulse=%b", resp, pulse);
    do_read(5'h1C, data, resp, to);
    n_vec++;
    if (to || data !== 32'h0 || resp !== 2'b10) begin
      n_err++; $display("FAIL unmapped_read: got data=%h resp=%b expected 00000000 10", data, resp);
    end
    $display("read  addr=1c data=%h resp=%b", data, resp);
  endtask

  task automatic test_collision();
    logic [31:0] old_val = model[0];
    s_axi_awaddr = 5'h00; s_axi_wdata = ~old_val; s_axi_wstrb = 4'hF;
    s_axi_araddr = 5'h00;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge clock);
    n_vec++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      n_err++; $display("FAIL collide_accept: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    @(posedge clock); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    model_write(5'h00, ~old_val, 4'hF);
    @(negedge clock);
    n_vec++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== old_val || ctrl_regs[31:0] !== ~old_val) begin
      n_err++; $display("FAIL collide_old_value: got rvalid=%b rdata=%h reg0=%h expected 1 %h %h", s_axi_rvalid, s_axi_rdata, ctrl_regs[31:0], old_val, ~old_val);
    end
    $display("collide addr=00 rdata=%h reg0=%h", s_axi_rdata, ctrl_regs[31:0]);
    @(posedge clock); #1 s_axi_bready = 1'b0; s_axi_rready = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] data, wd; logic [3:0] strb;
    logic [2:0] word; logic [1:0] lo; logic [4:0] a; bit to;
    for (int t = 0; t < 40; t++) begin
      word = 3'($urandom_range(0, 7));
      lo   = 2'($urandom);
      a    = {word, lo};
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; strb = 4'($urandom);
        do_write(a, wd, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse, to);
        model_write(a, wd, strb);
        n_vec++;
        if (to || resp !== exp_resp(a) || pulse !== exp_pulse(a, strb) || ctrl_regs !== model_vec()) begin
          n_err++; $display("FAIL rand_write[%0d]: got resp=%b pulse=%b regs=%h expected %b %b %h", t, resp, pulse, ctrl_regs, exp_resp(a), exp_pulse(a, strb), model_vec());
        end
        $display("write addr=%h data=%h strb=%h resp=%b pulse=%b", a, wd, strb, resp, pulse);
      end else begin
        status_in = $urandom;
        do_read(a, data, resp, to);
        n_vec++;
        if (to || data !== exp_rdata(a) || resp !== exp_resp(a)) begin
          n_err++; $display("FAIL rand_read[%0d]: got data=%h resp=%b expected %h %b", t, data, resp, exp_rdata(a), exp_resp(a));
        end
        $display("read  addr=%h data=%h resp=%b", a, data, resp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [1:0] resp; logic [3:0] pulse; logic [31:0] data; bit to;
    do_write(5'h0C, 32'h5A5A_0F0F, 4'hF, 0, 0, resp, pulse, to);
    model_write(5'h0C, 32'h5A5A_0F0F, 4'hF);
    s_axi_araddr = 5'h0C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    @(posedge clock); #1 s_axi_arvalid = 1'b0;
    @(negedge clock);
    n_vec++;
    if (s_axi_rvalid !== 1'b1) begin n_err++; $display("FAIL midrst_rvalid_before: got %b expected 1", s_axi_rvalid); end
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    n_vec++;
    if (s_axi_rvalid !== 1'b0 || ctrl_regs !== 128'h0) begin
      n_err++; $display("FAIL midrst_clear: got rvalid=%b regs=%h expected 0 0", s_axi_rvalid, ctrl_regs);
    end
    $display("reset during pending read rvalid=%b", s_axi_rvalid);
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    do_read(5'h0C, data, resp, to);
    n_vec++;
    if (to || data !== 32'h0 || resp !== 2'b00) begin
      n_err++; $display("FAIL midrst_readback: got data=%h resp=%b expected 0 00", data, resp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_w_before_aw();
    test_strobes();
    test_status_unmapped();
    test_collision();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_axil_slave_regs.md
Name: fir_axil_slave_regs

Overview:
- AXI4-Lite slave register interface for the FIR filter IP; it is the responder to the AXI4-Lite master agent that drives writes and read-backs on the S00_AXI port.
- Holds four 32-bit read/write control registers (coefficient/config words) and one read-only status word.
- Exposes register contents and per-register write pulses to the FIR datapath.
- Single outstanding write and single outstanding read; the read and write channels operate independently.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; covers offsets 0x00-0x1C.
- REG_RESET_VAL, 32'h0000_0000, reset value of all four RW registers.

Ports:
- clock  in  1  ACLK, all logic on rising edge
- reset  in  1  synchronous, active-high
- s_axi_awaddr  in  5  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  5  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- ctrl_regs  out  128  reg3..reg0 concatenated; reg0 occupies bits [31:0]
- reg_wr_pulse  out  4  one-cycle strobe per RW register, asserted on commit
- status_in  in  32  sampled value for the RO register at 0x10

Behaviour:
- Address map (awaddr/araddr bits [1:0] ignored):
  - 0x00, 0x04, 0x08, 0x0C: RW reg0-reg3.
  - 0x10: status, read-only; writes are ignored and return OKAY.
  - 0x14-0x1C: unmapped; writes are discarded with SLVERR (2'b10); reads return 0 with SLVERR.
- Reset:
  - All registered outputs are 0: readies, bvalid, rvalid, bresp, rresp, rdata, reg_wr_pulse.
  - ctrl_regs = REG_RESET_VAL.
  - Latched AW/W and in-flight responses are discarded.
  - Readies rise in the first cycle after reset deasserts.
- Write FSM, states W_IDLE, W_RESP:
  - In W_IDLE, awready = 1 until an AW is latched and wready = 1 until a W is latched. AW and W may arrive in either order or in the same cycle.
  - In the cycle holding both latches, commit takes effect at the closing edge:
    - Register bytes are updated per wstrb; unset strobe bytes are preserved.
    - The matching reg_wr_pulse bit is high in the next cycle for exactly 1 cycle.
    - bvalid = 1 and the FSM enters W_RESP.
  - Latency: AW and W handshakes in the same cycle N give bvalid at N+1 and the register visible at N+1.
  - In W_RESP, awready = wready = 0. bvalid is held with stable bresp until bready. Readies return in the cycle after the B handshake.
  - A write with wstrb = 0 still responds OKAY, with no data change and no pulse.
- Read FSM, states R_IDLE, R_DATA:
  - arready = 1 in R_IDLE.
  - On AR handshake at cycle N, rdata/rresp are captured from current register values at the closing edge, and rvalid = 1 at N+1.
  - rdata and rvalid are held stable until rready; arready = 0 meanwhile.
- Simultaneous read and write of the same register: if the AR handshake and the write commit close on the same edge, the read returns the old value.
- status_in is sampled only on the AR handshake.
- bvalid/rvalid are never asserted without a prior handshake. Valid/ready never combinationally depend on each other across channels.

Decomposition:
- Package fir_axil_pkg:
  - AXI resp constants: OKAY 2'b00, SLVERR 2'b10.
  - Register offset localparams: REG0_OFS through STATUS_OFS.
  - Write and read FSM state enums.
  - Function addr_to_index.
- Sub-module fir_axil_reg_bank: holds the four RW registers, does the wstrb byte merge and pulse generation, and is written via index/data/strb/we.
- Handshake FSMs remain in the top-level module.

Test Plan:
- Reset then idle:
  - Expect awready = wready = arready = 1 one cycle after reset falls.
  - ctrl_regs = 0; bvalid = rvalid = 0.
- Write 0x1, 0x2, 0x3, 0x4 to 0x00-0x0C with wstrb = 0xF, then read back each:
  - rdata matches each value; all responses OKAY.
  - reg_wr_pulse shows 0001, 0010, 0100, 1000 on successive commits.
- W presented 3 cycles before AW on 0x04 (data 0xDEADBEEF):
  - wready drops after the W handshake; bvalid comes 1 cycle after the AW handshake.
  - reg1 = 0xDEADBEEF.
- Byte strobes:
  - Write 0xAABBCCDD with wstrb = 0x5 to reg2 holding 0x11223344 -> reg2 = 0x11BB33DD.
  - Hold bready = 0 for 4 cycles -> bvalid and bresp stay stable; no new AW is accepted.
- Read 0x10 with status_in = 0x0000_00A5 -> rdata = 0xA5, OKAY.
- Write to 0x18 -> SLVERR, no register change, no pulse. Read 0x1C -> rdata = 0, SLVERR.
- Mid-operation reset: assert reset while rvalid = 1 and rready = 0 -> rvalid = 0 and ctrl_regs = 0 in the next cycle.
